sd_dat_serial_wrapper: RTL and testbench
========================================

Name: sd_dat_serial_wrapper

Overview:
Bit-level DAT0 engine between the DAT physical controller and the pad.
- Write: serialises one WORD_W-bit block with start bit, CRC16 and end bit, then receives the card's CRC status token and busy.
- Read: deserialises one block and checks its CRC16.
- All sequencing decisions (block count, timeout, FIFO access) stay in the controller; this block only reports level-held completion flags.

Parameters:
WORD_W, 32, payload bits per block, MSB first
CRC_W, 16, CRC length; polynomial x^16+x^12+x^5+1, init 0

Ports:
sd_clock  in  1  clock
reset  in  1  synchronous, active-high; clock sd_clock
reset_wrapper  in  1  soft clear: returns FSM to IDLE and clears flags, same effect as reset
load_send  in  1  start transmit of data_in (qualified by enable_pts)
enable_pts  in  1  transmit path enable
enable_stp  in  1  receive path enable
waiting_response  in  1  controller is in response phase after a write
data_in  in  WORD_W  block to transmit
dat_in  in  1  DAT0 from pad
dat_out  out  1  DAT0 to pad
dat_oe  out  1  pad drive enable
transmission_complete  out  1  level; frame fully shifted
reception_complete  out  1  level; response or read block finished
data_read  out  WORD_W  received block
crc_status  out  3  status bits of the write CRC token
crc_error  out  1  read CRC mismatch, or write token not 3'b010

Behaviour:
- Reset or reset_wrapper (synchronous, reset has priority):
  - state=IDLE; dat_out=1, dat_oe=0.
  - Both complete flags=0, data_read=0, crc_status=0, crc_error=0.
  - Bit counter and CRC register=0.
- Transmit sequence:
  - IDLE -> TX_START when enable_pts && load_send. data_in is latched and the CRC is cleared on that edge.
  - TX_START: dat_oe=1, dat_out=0 for 1 cycle.
  - TX_DATA: WORD_W cycles, MSB first; each bit is fed into the CRC.
  - TX_CRC: CRC_W cycles, MSB first.
  - TX_END: dat_out=1 for 1 cycle.
  - TX_DONE: dat_oe=0; transmission_complete set on entry and held.
  - Total dat_oe-high span = WORD_W+CRC_W+2 cycles (50 at defaults). The start bit is driven the cycle after load acceptance.
- Write response:
  - TX_DONE -> RSP_WAIT_START when waiting_response && enable_stp.
  - RSP_WAIT_START: waits for dat_in==0.
  - RSP_STATUS: samples 3 bits into crc_status, MSB first.
  - RSP_END: samples the end bit; crc_error=1 if crc_status!=3'b010 or end bit==0.
  - RSP_END -> RSP_BUSY (feature on) or DONE.
  - RSP_BUSY: waits for dat_in==1, then DONE.
- Read:
  - IDLE -> RX_WAIT_START when enable_stp && !enable_pts.
  - RX_WAIT_START: waits for dat_in==0.
  - RX_DATA: WORD_W bits shifted into a shift register, fed into the CRC.
  - RX_CRC: CRC_W bits compared bitwise against the computed CRC; any mismatch sets a sticky mismatch bit.
  - RX_END: samples the end bit; data_read updated from the shift register. crc_error = mismatch | (end bit==0).
  - RX_END -> DONE.
- DONE: reception_complete=1 and held. Exits only via reset_wrapper or reset.
- Holding and ignored inputs:
  - In DONE and TX_DONE, load_send is ignored.
  - load_send is ignored in every state except IDLE.
  - Dropping enable_pts or enable_stp mid-frame does not abort; only reset_wrapper or reset aborts.
- Simultaneous load_send and enable_stp in IDLE: the transmit path wins.
- No internal timeout; an absent start bit waits indefinitely (the controller owns DATA_TIMEOUT).
- The bit counter is 6 bits and must cover max(WORD_W, CRC_W)-1. There is no wrap-around; the counter reloads on each phase entry.

Optional Feature:
SD_DAT_BUSY_WAIT_EN
- Defined: RSP_BUSY is compiled in; reception_complete asserts only after dat_in returns to 1 following the CRC token.
- Undefined: RSP_BUSY is absent; reception_complete asserts the cycle after RSP_END samples the end bit, and busy is ignored.

Test Plan:
- Write, data_in=32'h0000_0000, load_send 1 cycle -> dat_out = 0, 48x 0, 1 over 50 cycles with dat_oe=1; transmission_complete on cycle 51 and held.
- Write, data_in=32'hA5A5_1234 -> 32 data bits match MSB first; 16 CRC bits match the bench CRC16 model.
- After write, token 0,0,1,0,1 then dat_in low 5 cycles -> crc_status=3'b010, crc_error=0.
  - Macro on: reception_complete 1 cycle after dat_in returns high.
  - Macro off: reception_complete immediately after the end bit, ignoring busy.
- Read, card sends 0, 32'hDEAD_BEEF, correct CRC, 1 -> data_read=32'hDEAD_BEEF, crc_error=0, reception_complete held until reset_wrapper.
- Read with one CRC bit flipped -> crc_error=1, reception_complete=1; bad token 3'b101 on write -> crc_error=1.
- reset_wrapper mid-TX_DATA (bit 10) -> next cycle dat_oe=0, dat_out=1, flags 0, state IDLE; a new load_send restarts with a clean CRC.

Source files
------------

// File: rtl/sd_dat_serial_wrapper_if.sv
// Bundle of the controller-facing and pad-facing signals of the DAT0 serial engine.
// master: the DAT physical controller plus pad model; slave: the serial engine.
interface sd_dat_serial_wrapper_if #(
    parameter int unsigned WORD_W = 32
);
    logic              reset_wrapper;
    logic              load_send;
    logic              enable_pts;
    logic              enable_stp;
    logic              waiting_response;
    logic [WORD_W-1:0] data_in;
    logic              dat_in;
    logic              dat_out;
    logic              dat_oe;
    logic              transmission_complete;
    logic              reception_complete;
    logic [WORD_W-1:0] data_read;
    logic [2:0]        crc_status;
    logic              crc_error;

    modport master (
        output reset_wrapper, load_send, enable_pts, enable_stp, waiting_response,
        output data_in, dat_in,
        input  dat_out, dat_oe, transmission_complete, reception_complete,
        input  data_read, crc_status, crc_error
    );

    modport slave (
        input  reset_wrapper, load_send, enable_pts, enable_stp, waiting_response,
        input  data_in, dat_in,
        output dat_out, dat_oe, transmission_complete, reception_complete,
        output data_read, crc_status, crc_error
    );
endinterface

// File: rtl/sd_dat_serial_wrapper.sv
// Bit-level DAT0 engine: serialises a write block (start, data, CRC16, end), collects the
// card's CRC status token, and deserialises/CRC-checks a read block.
// Optional macro SD_DAT_BUSY_WAIT_EN: when defined, the write response also waits for the
// card to release busy (DAT0 back high) before reporting reception_complete.
module sd_dat_serial_wrapper #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned CRC_W  = 16
) (
    input logic                   sd_clock,
    input logic                   reset,
    sd_dat_serial_wrapper_if.slave bus
);
    // Counter is 6 bits; WORD_W and CRC_W must both be <= 64.
    localparam logic [5:0]       LastWord = 6'(WORD_W - 1);
    localparam logic [5:0]       LastCrc  = 6'(CRC_W - 1);
    localparam logic [5:0]       LastStat = 6'd2;
    localparam logic [CRC_W-1:0] CrcPoly  = CRC_W'(16'h1021);

    typedef enum logic [3:0] {
        StIdle,
        StTxStart,
        StTxData,
        StTxCrc,
        StTxEnd,
        StTxDone,
        StRspWaitStart,
        StRspStatus,
        StRspEnd,
`ifdef SD_DAT_BUSY_WAIT_EN
        StRspBusy,
`endif
        StRxWaitStart,
        StRxData,
        StRxCrc,
        StRxEnd,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic              mismatch_q, mismatch_d;
    logic [2:0]        status_q, status_d;
    logic              error_q, error_d;
    logic [WORD_W-1:0] data_read_q, data_read_d;
    logic              tx_done_q, tx_done_d;
    logic              rx_done_q, rx_done_d;
    logic              dat_out_c, dat_oe_c;

    // One serial step of the CRC16 (x^16+x^12+x^5+1) LFSR.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                  input logic bit_in);
        logic fb;
        fb = crc[CRC_W-1] ^ bit_in;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CrcPoly : '0);
    endfunction

    // State and datapath registers; reset and the soft clear both return everything to zero.
    always_ff @(posedge sd_clock) begin
        if (reset || bus.reset_wrapper) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            crc_q       <= '0;
            mismatch_q  <= 1'b0;
            status_q    <= '0;
            error_q     <= 1'b0;
            data_read_q <= '0;
            tx_done_q   <= 1'b0;
            rx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            crc_q       <= crc_d;
            mismatch_q  <= mismatch_d;
            status_q    <= status_d;
            error_q     <= error_d;
            data_read_q <= data_read_d;
            tx_done_q   <= tx_done_d;
            rx_done_q   <= rx_done_d;
        end
    end

    // Next-state, datapath updates and pad drive decoded from the current state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        crc_d       = crc_q;
        mismatch_d  = mismatch_q;
        status_d    = status_q;
        error_d     = error_q;
        data_read_d = data_read_q;
        tx_done_d   = tx_done_q;
        rx_done_d   = rx_done_q;
        dat_out_c   = 1'b1;
        dat_oe_c    = 1'b0;

        case (state_q)
            StIdle: begin
                // Transmit wins when both paths are requested together.
                if (bus.enable_pts && bus.load_send) begin
                    state_d = StTxStart;
                    shift_d = bus.data_in;
                    crc_d   = '0;
                end else if (bus.enable_stp && !bus.enable_pts) begin
                    state_d = StRxWaitStart;
                end
            end
            StTxStart: begin
                dat_oe_c  = 1'b1;
                dat_out_c = 1'b0;
                state_d   = StTxData;
                cnt_d     = '0;
            end
            StTxData: begin
                dat_oe_c  = 1'b1;
                dat_out_c = shift_q[WORD_W-1];
                crc_d     = crc_step(crc_q, shift_q[WORD_W-1]);
                shift_d   = {shift_q[WORD_W-2:0], 1'b0};
                if (cnt_q == LastWord) begin
                    state_d = StTxCrc;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StTxCrc: begin
                dat_oe_c  = 1'b1;
                dat_out_c = crc_q[CRC_W-1];
                crc_d     = {crc_q[CRC_W-2:0], 1'b0};
                if (cnt_q == LastCrc) begin
                    state_d = StTxEnd;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StTxEnd: begin
                dat_oe_c  = 1'b1;
                state_d   = StTxDone;
                tx_done_d = 1'b1;
            end
            StTxDone: begin
                if (bus.waiting_response && bus.enable_stp) begin
                    state_d = StRspWaitStart;
                end
            end
            StRspWaitStart: begin
                if (!bus.dat_in) begin
                    state_d = StRspStatus;
                    cnt_d   = '0;
                end
            end
            StRspStatus: begin
                status_d = {status_q[1:0], bus.dat_in};
                if (cnt_q == LastStat) begin
                    state_d = StRspEnd;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StRspEnd: begin
                error_d = (status_q != 3'b010) || !bus.dat_in;
`ifdef SD_DAT_BUSY_WAIT_EN
                state_d = StRspBusy;
`else
                state_d   = StDone;
                rx_done_d = 1'b1;
`endif
            end
`ifdef SD_DAT_BUSY_WAIT_EN
            StRspBusy: begin
                // Card holds DAT0 low while programming; completion waits for release.
                if (bus.dat_in) begin
                    state_d   = StDone;
                    rx_done_d = 1'b1;
                end
            end
`endif
            StRxWaitStart: begin
                if (!bus.dat_in) begin
                    state_d    = StRxData;
                    cnt_d      = '0;
                    crc_d      = '0;
                    mismatch_d = 1'b0;
                end
            end
            StRxData: begin
                shift_d = {shift_q[WORD_W-2:0], bus.dat_in};
                crc_d   = crc_step(crc_q, bus.dat_in);
                if (cnt_q == LastWord) begin
                    state_d = StRxCrc;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StRxCrc: begin
                if (bus.dat_in != crc_q[CRC_W-1]) begin
                    mismatch_d = 1'b1;
                end
                crc_d = {crc_q[CRC_W-2:0], 1'b0};
                if (cnt_q == LastCrc) begin
                    state_d = StRxEnd;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StRxEnd: begin
                data_read_d = shift_q;
                error_d     = mismatch_q | !bus.dat_in;
                state_d     = StDone;
                rx_done_d   = 1'b1;
            end
            StDone: begin
                // Held until the controller issues reset_wrapper.
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.dat_out               = dat_out_c;
    assign bus.dat_oe                = dat_oe_c;
    assign bus.transmission_complete = tx_done_q;
    assign bus.reception_complete    = rx_done_q;
    assign bus.data_read             = data_read_q;
    assign bus.crc_status            = status_q;
    assign bus.crc_error             = error_q;

endmodule

// File: tb/tb_sd_dat_serial_wrapper.sv
// Directed bench for sd_dat_serial_wrapper: write frames, write response tokens, read blocks
// and soft-clear behaviour, driven from small vector tables plus a few hand sequences.
module tb_sd_dat_serial_wrapper;
    logic sd_clock;
    logic reset;
    int   checks;
    int   errors;

    sd_dat_serial_wrapper_if #(.WORD_W(32)) bus_if ();

    sd_dat_serial_wrapper #(
        .WORD_W(32),
        .CRC_W (16)
    ) dut (
        .sd_clock(sd_clock),
        .reset   (reset),
        .bus     (bus_if)
    );

    initial sd_clock = 1'b0;
    always #5 sd_clock = ~sd_clock;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  status;
        logic        end_bit;
        logic        exp_err;
    } wr_vec_t;

    typedef struct {
        logic [31:0] data;
        logic [15:0] flip;
        logic        end_bit;
        logic        exp_err;
    } rd_vec_t;

    wr_vec_t wr_tab[4];
    rd_vec_t rd_tab[4];

    // Reference CRC16, init 0, data MSB first, taps applied explicitly.
    function automatic logic [15:0] crc16(input logic [31:0] d);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        for (int i = 31; i >= 0; i--) begin
            fb    = c[15] ^ d[i];
            c     = c << 1;
            c[0]  = fb;
            c[5]  = c[5] ^ fb;
            c[12] = c[12] ^ fb;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge sd_clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic soft_clear();
        bus_if.reset_wrapper = 1'b1;
        tick();
        bus_if.reset_wrapper = 1'b0;
    endtask

    task automatic write_frame(input logic [31:0] data);
        logic [49:0] cap;
        logic [49:0] expf;
        logic        oe_ok;
        expf = {1'b0, data, crc16(data), 1'b1};
        bus_if.data_in    = data;
        bus_if.enable_pts = 1'b1;
        bus_if.enable_stp = 1'b1;   // transmit must win over receive
        bus_if.load_send  = 1'b1;
        tick();
        bus_if.load_send  = 1'b0;
        bus_if.enable_stp = 1'b0;
        check("tx_complete_low_at_start", 64'(bus_if.transmission_complete), 64'd0);
        cap   = '0;
        oe_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cap = {cap[48:0], bus_if.dat_out};
            if (bus_if.dat_oe !== 1'b1) oe_ok = 1'b0;
            tick();
        end
        check("tx_frame", 64'(cap), 64'(expf));
        check("tx_oe_span", 64'(oe_ok), 64'd1);
        check("tx_complete_c51", 64'(bus_if.transmission_complete), 64'd1);
        check("tx_oe_off", 64'(bus_if.dat_oe), 64'd0);
        // load_send in TX_DONE must be ignored
        bus_if.load_send = 1'b1;
        tick();
        bus_if.load_send = 1'b0;
        check("tx_complete_held", 64'(bus_if.transmission_complete), 64'd1);
        check("tx_reload_ignored", 64'(bus_if.dat_oe), 64'd0);
    endtask

    task automatic write_response(input logic [2:0] status, input logic end_bit,
                                  input logic exp_err);
        bus_if.dat_in           = 1'b1;
        bus_if.waiting_response = 1'b1;
        bus_if.enable_stp       = 1'b1;
        tick();
        tick();
        bus_if.dat_in = 1'b0;
        tick();
        for (int i = 2; i >= 0; i--) begin
            bus_if.dat_in = status[i];
            tick();
        end
        bus_if.dat_in = end_bit;
        tick();
        bus_if.dat_in = 1'b0;
`ifdef SD_DAT_BUSY_WAIT_EN
        check("rsp_busy_not_done", 64'(bus_if.reception_complete), 64'd0);
        repeat (5) tick();
        check("rsp_busy_still_waiting", 64'(bus_if.reception_complete), 64'd0);
        bus_if.dat_in = 1'b1;
        tick();
        check("rsp_done_after_busy", 64'(bus_if.reception_complete), 64'd1);
`else
        check("rsp_done_after_end", 64'(bus_if.reception_complete), 64'd1);
        repeat (5) tick();
        bus_if.dat_in = 1'b1;
        tick();
        check("rsp_done_held", 64'(bus_if.reception_complete), 64'd1);
`endif
        check("rsp_crc_status", 64'(bus_if.crc_status), 64'(status));
        check("rsp_crc_error", 64'(bus_if.crc_error), 64'(exp_err));
        bus_if.waiting_response = 1'b0;
        bus_if.enable_stp       = 1'b0;
        bus_if.enable_pts       = 1'b0;
        soft_clear();
        check("rsp_clear_rx", 64'(bus_if.reception_complete), 64'd0);
        check("rsp_clear_tx", 64'(bus_if.transmission_complete), 64'd0);
    endtask

    task automatic read_block(input logic [31:0] data, input logic [15:0] flip,
                              input logic end_bit, input logic exp_err);
        logic [15:0] crc;
        crc               = crc16(data) ^ flip;
        bus_if.enable_pts = 1'b0;
        bus_if.enable_stp = 1'b1;
        bus_if.dat_in     = 1'b1;
        tick();
        tick();
        bus_if.dat_in = 1'b0;
        tick();
        for (int i = 31; i >= 0; i--) begin
            bus_if.dat_in = data[i];
            tick();
        end
        for (int i = 15; i >= 0; i--) begin
            bus_if.dat_in = crc[i];
            tick();
        end
        bus_if.dat_in = end_bit;
        tick();
        check("rd_complete", 64'(bus_if.reception_complete), 64'd1);
        check("rd_data", 64'(bus_if.data_read), 64'(data));
        check("rd_crc_error", 64'(bus_if.crc_error), 64'(exp_err));
        // load_send in DONE must be ignored
        bus_if.dat_in     = 1'b1;
        bus_if.enable_pts = 1'b1;
        bus_if.load_send  = 1'b1;
        tick();
        bus_if.load_send  = 1'b0;
        bus_if.enable_pts = 1'b0;
        tick();
        check("rd_done_no_tx", 64'(bus_if.dat_oe), 64'd0);
        check("rd_complete_held", 64'(bus_if.reception_complete), 64'd1);
        bus_if.enable_stp = 1'b0;
        soft_clear();
        check("rd_clear_complete", 64'(bus_if.reception_complete), 64'd0);
        check("rd_clear_data", 64'(bus_if.data_read), 64'd0);
        check("rd_clear_error", 64'(bus_if.crc_error), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        wr_tab[0] = '{data: 32'h0000_0000, status: 3'b010, end_bit: 1'b1, exp_err: 1'b0};
        wr_tab[1] = '{data: 32'hA5A5_1234, status: 3'b010, end_bit: 1'b1, exp_err: 1'b0};
        wr_tab[2] = '{data: 32'hFFFF_0001, status: 3'b101, end_bit: 1'b1, exp_err: 1'b1};
        wr_tab[3] = '{data: 32'h1234_5678, status: 3'b010, end_bit: 1'b0, exp_err: 1'b1};

        rd_tab[0] = '{data: 32'hDEAD_BEEF, flip: 16'h0000, end_bit: 1'b1, exp_err: 1'b0};
        rd_tab[1] = '{data: 32'hDEAD_BEEF, flip: 16'h0100, end_bit: 1'b1, exp_err: 1'b1};
        rd_tab[2] = '{data: 32'h0000_0000, flip: 16'h0000, end_bit: 1'b1, exp_err: 1'b0};
        rd_tab[3] = '{data: 32'h8000_0001, flip: 16'h0000, end_bit: 1'b0, exp_err: 1'b1};

        bus_if.reset_wrapper    = 1'b0;
        bus_if.load_send        = 1'b0;
        bus_if.enable_pts       = 1'b0;
        bus_if.enable_stp       = 1'b0;
        bus_if.waiting_response = 1'b0;
        bus_if.data_in          = '0;
        bus_if.dat_in           = 1'b1;
        reset                   = 1'b1;
        tick();
        tick();
        check("rst_dat_out", 64'(bus_if.dat_out), 64'd1);
        check("rst_dat_oe", 64'(bus_if.dat_oe), 64'd0);
        check("rst_tx_complete", 64'(bus_if.transmission_complete), 64'd0);
        check("rst_rx_complete", 64'(bus_if.reception_complete), 64'd0);
        check("rst_data_read", 64'(bus_if.data_read), 64'd0);
        check("rst_crc_status", 64'(bus_if.crc_status), 64'd0);
        check("rst_crc_error", 64'(bus_if.crc_error), 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            write_frame(wr_tab[i].data);
            write_response(wr_tab[i].status, wr_tab[i].end_bit, wr_tab[i].exp_err);
        end

        for (int i = 0; i < 4; i++) begin
            read_block(rd_tab[i].data, rd_tab[i].flip, rd_tab[i].end_bit, rd_tab[i].exp_err);
        end

        // Abort a write at data bit 10, then restart it from a clean CRC.
        bus_if.data_in    = 32'hA5A5_1234;
        bus_if.enable_pts = 1'b1;
        bus_if.load_send  = 1'b1;
        tick();
        bus_if.load_send = 1'b0;
        repeat (11) tick();
        check("abort_mid_oe", 64'(bus_if.dat_oe), 64'd1);
        check("abort_mid_bit10", 64'(bus_if.dat_out), 64'(1'b1));
        bus_if.reset_wrapper = 1'b1;
        tick();
        bus_if.reset_wrapper = 1'b0;
        check("abort_oe", 64'(bus_if.dat_oe), 64'd0);
        check("abort_dat_out", 64'(bus_if.dat_out), 64'd1);
        check("abort_tx_complete", 64'(bus_if.transmission_complete), 64'd0);
        check("abort_rx_complete", 64'(bus_if.reception_complete), 64'd0);
        tick();
        check("abort_stays_idle", 64'(bus_if.dat_oe), 64'd0);
        write_frame(32'hA5A5_1234);
        bus_if.enable_pts = 1'b0;
        soft_clear();
        check("final_idle_oe", 64'(bus_if.dat_oe), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
